sm_addsub_pipe: RTL and testbench



---
 rtl/sm_pkg.sv | 17 +
 rtl/sm_mag_core.sv | 31 +++
 rtl/sm_addsub_pipe.sv | 90 +++++++++
 tb/tb_sm_addsub_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sm_pkg.sv
// rtl/sm_pkg.sv - shared constants and helpers for the sign-magnitude arithmetic blocks
package sm_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int sm_sign_bit(input int width);
        return width - 1;
    endfunction

    function automatic logic sm_is_zero(input logic [63:0] value, input int width);
        logic [63:0] mask;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value & mask) == 64'd0;
    endfunction

endpackage

// File: rtl/sm_mag_core.sv
// rtl/sm_mag_core.sv - combinational magnitude add/subtract with overflow, saturation and -0 removal
module sm_mag_core
    import sm_pkg::*;
#(
    parameter int n        = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic         same_sign,
    input  logic [n-2:0] ml,
    input  logic [n-2:0] ms,
    input  logic         sign,
    output logic [n-1:0] res,
    output logic         ovf
);

    logic [n-1:0] sum;
    logic [n-2:0] mag;

    // ml >= ms is guaranteed by the decode stage, so the difference never borrows
    always_comb begin
        sum = {1'b0, ml} + {1'b0, ms};
        ovf = 1'b0;
        mag = ml - ms;
        if (same_sign) begin
            ovf = sum[n-1];
            mag = (SATURATE && sum[n-1]) ? '1 : sum[n-2:0];
        end
        res = {sign & !sm_is_zero(64'(mag), n - 1), mag};
    end

endmodule

// File: rtl/sm_addsub_pipe.sv
// rtl/sm_addsub_pipe.sv - two-stage sign-magnitude adder/subtractor with valid/ready handshake
module sm_addsub_pipe
    import sm_pkg::*;
#(
    parameter int n        = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] opA,
    input  logic [n-1:0] opB,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] res,
    output logic         ovf
);

    localparam int SB = sm_sign_bit(n);
    localparam int MW = n - 1;

    logic          v1, v2, adv1, adv2;
    logic [MW-1:0] ma, mb;
    logic          sa, sb, a_ge;
    logic          s1_same, s1_sign;
    logic [MW-1:0] s1_ml, s1_ms;
    logic [n-1:0]  core_res;
    logic          core_ovf;

    assign adv2      = !v2 || out_ready;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v2;

    // Zero magnitudes decode as +0 so a stray sign bit cannot steer the result sign
    always_comb begin
        ma   = opA[MW-1:0];
        mb   = opB[MW-1:0];
        sa   = opA[SB] & !sm_is_zero(64'(ma), MW);
        sb   = (opB[SB] ^ (mode == OP_SUB)) & !sm_is_zero(64'(mb), MW);
        a_ge = ma >= mb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            s1_same <= 1'b0;
            s1_sign <= 1'b0;
            s1_ml   <= '0;
            s1_ms   <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_same <= (sa == sb);
                s1_ml   <= a_ge ? ma : mb;
                s1_ms   <= a_ge ? mb : ma;
                s1_sign <= a_ge ? sa : sb;
            end
        end
    end

    sm_mag_core #(
        .n        (n),
        .SATURATE (SATURATE)
    ) u_core (
        .same_sign (s1_same),
        .ml        (s1_ml),
        .ms        (s1_ms),
        .sign      (s1_sign),
        .res       (core_res),
        .ovf       (core_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v2  <= 1'b0;
            res <= '0;
            ovf <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                res <= core_res;
                ovf <= core_ovf;
            end
        end
    end

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// tb/tb_sm_addsub_pipe.sv - self-checking bench for sm_addsub_pipe across width and saturation variants
module tb_sm_addsub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, mode, out_ready;
    logic [7:0] opa8, opb8;
    logic [3:0] opa4, opb4;
    assign opa4 = opa8[3:0];
    assign opb4 = opb8[3:0];

    logic       ir_w4, ir_s4, ir_w8, ir_s8;
    logic       ov_w4, ov_s4, ov_w8, ov_s8;
    logic       of_w4, of_s4, of_w8, of_s8;
    logic [3:0] r_w4, r_s4;
    logic [7:0] r_w8, r_s8;

    sm_addsub_pipe #(.n(4), .SATURATE(1'b0)) u_w4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w4),
        .opA(opa4), .opB(opb4), .mode(mode), .out_valid(ov_w4), .out_ready(out_ready), .res(r_w4), .ovf(of_w4));
    sm_addsub_pipe #(.n(4), .SATURATE(1'b1)) u_s4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_s4),
        .opA(opa4), .opB(opb4), .mode(mode), .out_valid(ov_s4), .out_ready(out_ready), .res(r_s4), .ovf(of_s4));
    sm_addsub_pipe #(.n(8), .SATURATE(1'b0)) u_w8 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w8),
        .opA(opa8), .opB(opb8), .mode(mode), .out_valid(ov_w8), .out_ready(out_ready), .res(r_w8), .ovf(of_w8));
    sm_addsub_pipe #(.n(8), .SATURATE(1'b1)) u_s8 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_s8),
        .opA(opa8), .opB(opb8), .mode(mode), .out_valid(ov_s8), .out_ready(out_ready), .res(r_s8), .ovf(of_s8));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       m;
        int         cyc;
        int         stl;
    } beat_t;

    beat_t      q[$];
    int         total = 0, bad = 0, cycle = 0, stall_cnt = 0, nout = 0;
    logic       held = 1'b0, h_of = 1'b0, last_ir = 1'b0;
    logic [3:0] h_w4 = '0;
    logic [7:0] h_w8 = '0;
    logic [4:0] last_w4 = '0, last_s4 = '0;
    logic [8:0] last_w8 = '0, last_s8 = '0;

    // Signed-integer reference: {ovf, result} with the result in the low w bits
    function automatic logic [8:0] ref_sm(input int w, input bit sat, input logic [7:0] a, input logic [7:0] b,
                                          input logic m);
        int lim, va, vb, r, ar, mag;
        bit o, neg;
        lim = 1 << (w - 1);
        va  = int'(a) & (lim - 1);
        vb  = int'(b) & (lim - 1);
        if (a[w-1]) va = -va;
        if (b[w-1]) vb = -vb;
        r   = m ? va - vb : va + vb;
        ar  = (r < 0) ? -r : r;
        o   = ar >= lim;
        mag = !o ? ar : (sat ? lim - 1 : ar % lim);
        neg = (r < 0) && (mag != 0);
        return {o, 8'(mag + (neg ? lim : 0))};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        beat_t      e;
        logic [8:0] x;
        @(negedge clk);
        cycle++;
        last_ir = ir_w4;
        if (rst) begin
            q.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 32'(ov_w4), 1);
                chk("hold_res_w4", {of_w4, r_w4}, {h_of, h_w4});
                chk("hold_res_w8", r_w8, h_w8);
            end
            if (ov_w4 && out_ready) begin
                nout++;
                chk("out_has_ref", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    x = ref_sm(4, 1'b0, e.a, e.b, e.m);
                    chk("res_w4", {of_w4, r_w4}, {x[8], x[3:0]});
                    x = ref_sm(4, 1'b1, e.a, e.b, e.m);
                    chk("res_s4", {of_s4, r_s4}, {x[8], x[3:0]});
                    x = ref_sm(8, 1'b0, e.a, e.b, e.m);
                    chk("res_w8", {of_w8, r_w8}, x);
                    x = ref_sm(8, 1'b1, e.a, e.b, e.m);
                    chk("res_s8", {of_s8, r_s8}, x);
                    chk("valid_agree", {ov_s4, ov_w8, ov_s8}, 3'b111);
                    if (e.stl == stall_cnt) chk("latency", cycle - e.cyc, 2);
                    last_w4 = {of_w4, r_w4};
                    last_s4 = {of_s4, r_s4};
                    last_w8 = {of_w8, r_w8};
                    last_s8 = {of_s8, r_s8};
                end
            end
            if (in_valid && ir_w4) q.push_back('{opa8, opb8, mode, cycle, stall_cnt});
            if (ov_w4 && !out_ready) stall_cnt++;
            held = ov_w4 && !out_ready;
            h_of = of_w4;
            h_w4 = r_w4;
            h_w8 = r_w8;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic m);
        opa8     = a;
        opb8     = b;
        mode     = m;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        int sent, n0, acc, guard;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mode      = 1'b0;
        opa8      = '0;
        opb8      = '0;
        repeat (2) cyc();
        rst = 1'b0;
        chk("reset_out_valid", 32'(ov_w4), 0);
        chk("reset_res", {of_w4, r_w4, of_s8, r_s8}, 0);
        chk("reset_in_ready", 32'(ir_w4), 1);

        beat(8'h0F, 8'h06, 1'b0);
        chk("dir_add", last_w4, 5'b0_1001);
        beat(8'h0F, 8'h06, 1'b1);
        chk("dir_sub_wrap", last_w4, 5'b1_1101);
        chk("dir_sub_sat", last_s4, 5'b1_1111);
        beat(8'h03, 8'h0B, 1'b0);
        chk("dir_cancel", last_w4, 5'b0_0000);
        beat(8'h08, 8'h08, 1'b0);
        chk("dir_negzero4", last_w4, 5'b0_0000);
        beat(8'h80, 8'h80, 1'b1);
        chk("dir_negzero8", last_w8, 9'h000);
        beat(8'h7F, 8'h01, 1'b0);
        chk("dir_wrap_zero8", last_w8, 9'h100);
        chk("dir_sat8", last_s8, 9'h17F);

        sent = 0;
        n0   = nout;
        for (int k = 0; k < 10; k++) begin
            in_valid  = sent < 6;
            opa8      = 8'($urandom);
            opb8      = 8'($urandom);
            mode      = 1'($urandom);
            out_ready = !(k >= 3 && k < 7);
            cyc();
            if (in_valid && last_ir) sent++;
            if (k >= 3 && k < 7) chk("bp_in_ready", 32'(last_ir), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("bp_sent", sent, 6);
        chk("bp_received", nout - n0, 6);

        out_ready = 1'b0;
        beat(8'h25, 8'h13, 1'b0);
        in_valid = 1'b1;
        opa8     = 8'h91;
        cyc();
        in_valid = 1'b0;
        rst      = 1'b1;
        cyc();
        rst       = 1'b0;
        out_ready = 1'b1;
        chk("rst_out_valid", 32'(ov_w4), 0);
        chk("rst_res", {of_w4, r_w4, of_w8, r_w8}, 0);
        n0 = nout;
        repeat (3) cyc();
        chk("rst_no_stale", nout - n0, 0);
        beat(8'h85, 8'h03, 1'b1);
        chk("rst_next_beat", nout - n0, 1);
        chk("rst_next_res", last_w8, 9'h088);

        acc   = 0;
        guard = 0;
        while (acc < 10000 && guard < 60000) begin
            in_valid  = $urandom_range(0, 3) != 0;
            opa8      = 8'($urandom);
            opb8      = 8'($urandom);
            mode      = 1'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            cyc();
            if (in_valid && last_ir) acc++;
            guard++;
        end
        chk("sweep_accepted", acc, 10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("drain_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
